// File: rtl/dmem_dma_pkg.sv
// Shared types and constants for the data-memory copy DMA engine.
// Covers the FSM state encoding, the memory-mapped I/O addresses and the word-alignment helper.
package dmem_dma_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } dma_state_t;

    localparam logic [31:0] SW_ADDR    = 32'hC000_0000;
    localparam logic [31:0] LED_ADDR   = 32'hC000_0004;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    // Byte pointers are always word aligned; the low two address bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_copy_dma.sv
// Word-copy DMA engine sharing the dmem port with the CPU through a req/gnt arbiter.
// Optional fill mode (write a constant, no reads) is enabled by defining DMEM_DMA_FILL_EN.
module dmem_copy_dma
    import dmem_dma_pkg::*;
#(
    parameter int          LEN_W    = 8,
    parameter logic [31:0] ADDR_INC = 32'd4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic             we,
    output logic [31:0]      a,
    output logic [31:0]      wd,
    input  logic [31:0]      rd
`ifdef DMEM_DMA_FILL_EN
    ,
    input  logic             fill_mode,
    input  logic [31:0]      fill_val
`endif
);

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    dma_state_t       state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [31:0]      data_q, data_d;
    logic             aborted_q, aborted_d;
    logic             fill_q, fill_d;
    logic [31:0]      fval_q, fval_d;

    // State, pointer, count and data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            src_q     <= 32'd0;
            dst_q     <= 32'd0;
            rem_q     <= LEN_ZERO;
            data_q    <= 32'd0;
            aborted_q <= 1'b0;
            fill_q    <= 1'b0;
            fval_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            rem_q     <= rem_d;
            data_q    <= data_d;
            aborted_q <= aborted_d;
            fill_q    <= fill_d;
            fval_q    <= fval_d;
        end
    end

    // Next-state and bus outputs; we is gated by grant and abort in the same cycle.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        data_d    = data_q;
        aborted_d = 1'b0;
        fill_d    = fill_q;
        fval_d    = fval_q;
        bus_req   = 1'b0;
        we        = 1'b0;
        a         = 32'd0;
        wd        = 32'd0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != LEN_ZERO) begin
                        src_d   = word_align(src);
                        dst_d   = word_align(dst);
                        rem_d   = len;
`ifdef DMEM_DMA_FILL_EN
                        fill_d  = fill_mode;
                        fval_d  = fill_val;
`endif
                        state_d = REQ;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                bus_req = 1'b1;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else if (bus_gnt) begin
                    state_d = fill_q ? WR : RD;
                end else begin
                    state_d = REQ;
                end
            end
            RD: begin
                bus_req = 1'b1;
                a       = src_q;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else if (bus_gnt) begin
                    data_d  = rd;
                    state_d = WR;
                end else begin
                    state_d = RD;
                end
            end
            WR: begin
                bus_req = 1'b1;
                a       = dst_q;
                wd      = fill_q ? fval_q : data_q;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else if (bus_gnt) begin
                    we      = 1'b1;
                    src_d   = src_q + ADDR_INC;
                    dst_d   = dst_q + ADDR_INC;
                    rem_d   = rem_q - LEN_ONE;
                    if (rem_q == LEN_ONE) begin
                        state_d = DONE;
                    end else begin
                        state_d = fill_q ? WR : RD;
                    end
                end else begin
                    state_d = WR;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign aborted = aborted_q;

endmodule
